// File: rtl/uart_tx_line_arbiter.sv
// rtl/uart_tx_line_arbiter.sv - merges echo and result character streams onto one UART TX channel
module uart_tx_line_arbiter #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    RES_DEPTH  = 12,
    parameter int                    ECHO_DEPTH = 4,
    parameter bit                    ECHO_EN    = 1'b1,
    parameter bit                    CRLF_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CR_CODE    = 8'h0D,
    parameter logic [DATA_WIDTH-1:0] LF_CODE    = 8'h0A
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_echo_data,
    input  logic                  i_echo_valid,
    input  logic [DATA_WIDTH-1:0] i_res_data,
    input  logic                  i_res_valid,
    input  logic                  i_res_last,
    output logic                  o_res_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_done,
    output logic                  o_echo_overflow,
    output logic                  o_res_overflow
);

    localparam int RPW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int RCW = $clog2(RES_DEPTH + 1);
    localparam int EPW = (ECHO_DEPTH > 1) ? $clog2(ECHO_DEPTH) : 1;
    localparam int ECW = $clog2(ECHO_DEPTH + 1);

    localparam logic [RPW-1:0] RES_PTR_MAX   = RPW'(RES_DEPTH - 1);
    localparam logic [RCW-1:0] RES_CNT_FULL  = RCW'(RES_DEPTH);
    localparam logic [EPW-1:0] ECHO_PTR_MAX  = EPW'(ECHO_DEPTH - 1);
    localparam logic [ECW-1:0] ECHO_CNT_FULL = ECW'(ECHO_DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_ECHO, ST_RES, ST_CR, ST_LF} state_t;

    // Storage: echo holds bare characters, result holds {last, data}
    logic [DATA_WIDTH-1:0] echo_mem [ECHO_DEPTH];
    logic [DATA_WIDTH:0]   res_mem  [RES_DEPTH];

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [EPW-1:0]        echo_wr_ptr_q, echo_wr_ptr_d, echo_rd_ptr_q, echo_rd_ptr_d;
    logic [ECW-1:0]        echo_cnt_q, echo_cnt_d;
    logic [RPW-1:0]        res_wr_ptr_q, res_wr_ptr_d, res_rd_ptr_q, res_rd_ptr_d;
    logic [RCW-1:0]        res_cnt_q, res_cnt_d;
    logic [RCW-1:0]        line_cnt_q, line_cnt_d;
    logic                  echo_ovf_q, echo_ovf_d;
    logic                  res_ovf_q, res_ovf_d;

    logic                  echo_full, echo_empty, res_full, res_empty, res_eligible;
    logic                  echo_wr, echo_pop, res_wr, res_pop, line_inc, line_dec;
    logic [DATA_WIDTH-1:0] echo_head;
    logic [DATA_WIDTH:0]   res_head;

    // Next-state logic: FIFO bookkeeping, line counting and the arbitration FSM
    always_comb begin
        echo_full    = (echo_cnt_q == ECHO_CNT_FULL);
        echo_empty   = (echo_cnt_q == '0);
        res_full     = (res_cnt_q == RES_CNT_FULL);
        res_empty    = (res_cnt_q == '0);
        res_eligible = (line_cnt_q != '0) || res_full;
        echo_head    = echo_mem[echo_rd_ptr_q];
        res_head     = res_mem[res_rd_ptr_q];

        // Fullness is judged before any pop of this cycle
        echo_wr = ECHO_EN && i_echo_valid && !echo_full;
        res_wr  = i_res_valid && !res_full;

        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        echo_pop   = 1'b0;
        res_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (res_eligible && (echo_empty || res_full)) begin
                    state_d    = ST_RES;
                    tx_data_d  = res_head[DATA_WIDTH-1:0];
                    tx_valid_d = 1'b1;
                end else if (!echo_empty) begin
                    state_d    = ST_ECHO;
                    tx_data_d  = echo_head;
                    tx_valid_d = 1'b1;
                end
            end
            ST_ECHO: begin
                if (tx_valid_q && i_tx_done) begin
                    echo_pop   = 1'b1;
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_RES: begin
                if (tx_valid_q) begin
                    if (i_tx_done) begin
                        res_pop    = 1'b1;
                        tx_valid_d = 1'b0;
                        if (res_head[DATA_WIDTH]) begin
                            state_d = CRLF_EN ? ST_CR : ST_IDLE;
                        end
                    end
                end else if (!res_empty) begin
                    // A forced flush can leave the line unfinished; wait here for the rest
                    tx_data_d  = res_head[DATA_WIDTH-1:0];
                    tx_valid_d = 1'b1;
                end
            end
            ST_CR: begin
                if (!tx_valid_q) begin
                    tx_data_d  = CR_CODE;
                    tx_valid_d = 1'b1;
                end else if (i_tx_done) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_LF;
                end
            end
            ST_LF: begin
                if (!tx_valid_q) begin
                    tx_data_d  = LF_CODE;
                    tx_valid_d = 1'b1;
                end else if (i_tx_done) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        echo_wr_ptr_d = echo_wr_ptr_q;
        echo_rd_ptr_d = echo_rd_ptr_q;
        echo_cnt_d    = echo_cnt_q;
        if (echo_wr) echo_wr_ptr_d = (echo_wr_ptr_q == ECHO_PTR_MAX) ? '0 : echo_wr_ptr_q + EPW'(1);
        if (echo_pop) echo_rd_ptr_d = (echo_rd_ptr_q == ECHO_PTR_MAX) ? '0 : echo_rd_ptr_q + EPW'(1);
        case ({echo_wr, echo_pop})
            2'b10:   echo_cnt_d = echo_cnt_q + ECW'(1);
            2'b01:   echo_cnt_d = echo_cnt_q - ECW'(1);
            default: echo_cnt_d = echo_cnt_q;
        endcase

        res_wr_ptr_d = res_wr_ptr_q;
        res_rd_ptr_d = res_rd_ptr_q;
        res_cnt_d    = res_cnt_q;
        if (res_wr) res_wr_ptr_d = (res_wr_ptr_q == RES_PTR_MAX) ? '0 : res_wr_ptr_q + RPW'(1);
        if (res_pop) res_rd_ptr_d = (res_rd_ptr_q == RES_PTR_MAX) ? '0 : res_rd_ptr_q + RPW'(1);
        case ({res_wr, res_pop})
            2'b10:   res_cnt_d = res_cnt_q + RCW'(1);
            2'b01:   res_cnt_d = res_cnt_q - RCW'(1);
            default: res_cnt_d = res_cnt_q;
        endcase

        line_inc = res_wr && i_res_last;
        line_dec = res_pop && res_head[DATA_WIDTH];
        case ({line_inc, line_dec})
            2'b10:   line_cnt_d = line_cnt_q + RCW'(1);
            2'b01:   line_cnt_d = line_cnt_q - RCW'(1);
            default: line_cnt_d = line_cnt_q;
        endcase

        echo_ovf_d = echo_ovf_q || (ECHO_EN && i_echo_valid && echo_full);
        res_ovf_d  = res_ovf_q || (i_res_valid && res_full);
    end

    // State registers; reset discards everything buffered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            echo_wr_ptr_q <= '0;
            echo_rd_ptr_q <= '0;
            echo_cnt_q    <= '0;
            res_wr_ptr_q  <= '0;
            res_rd_ptr_q  <= '0;
            res_cnt_q     <= '0;
            line_cnt_q    <= '0;
            echo_ovf_q    <= 1'b0;
            res_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            echo_wr_ptr_q <= echo_wr_ptr_d;
            echo_rd_ptr_q <= echo_rd_ptr_d;
            echo_cnt_q    <= echo_cnt_d;
            res_wr_ptr_q  <= res_wr_ptr_d;
            res_rd_ptr_q  <= res_rd_ptr_d;
            res_cnt_q     <= res_cnt_d;
            line_cnt_q    <= line_cnt_d;
            echo_ovf_q    <= echo_ovf_d;
            res_ovf_q     <= res_ovf_d;
        end
    end

    // FIFO storage writes; contents need no reset since occupancy governs validity
    always_ff @(posedge i_clk) begin
        if (echo_wr) echo_mem[echo_wr_ptr_q] <= i_echo_data;
        if (res_wr) res_mem[res_wr_ptr_q] <= {i_res_last, i_res_data};
    end

    assign o_res_ready     = !res_full;
    assign o_tx_data       = tx_data_q;
    assign o_tx_valid      = tx_valid_q;
    assign o_echo_overflow = echo_ovf_q;
    assign o_res_overflow  = res_ovf_q;

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// tb/tb_uart_tx_line_arbiter.sv - scoreboard bench for uart_tx_line_arbiter
module tb_uart_tx_line_arbiter;

    localparam int         DW  = 8;
    localparam int         RD  = 12;
    localparam int         ED  = 4;
    localparam bit         EEN = 1'b1;
    localparam bit         CEN = 1'b1;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [DW-1:0] i_echo_data = '0;
    logic          i_echo_valid = 1'b0;
    logic [DW-1:0] i_res_data = '0;
    logic          i_res_valid = 1'b0;
    logic          i_res_last = 1'b0;
    logic          o_res_ready;
    logic [DW-1:0] o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_done = 1'b0;
    logic          o_echo_overflow;
    logic          o_res_overflow;

    uart_tx_line_arbiter #(
        .DATA_WIDTH(DW), .RES_DEPTH(RD), .ECHO_DEPTH(ED), .ECHO_EN(EEN),
        .CRLF_EN(CEN), .CR_CODE(CR), .LF_CODE(LF)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_echo_data(i_echo_data), .i_echo_valid(i_echo_valid),
        .i_res_data(i_res_data), .i_res_valid(i_res_valid), .i_res_last(i_res_last),
        .o_res_ready(o_res_ready), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
        .i_tx_done(i_tx_done), .o_echo_overflow(o_echo_overflow), .o_res_overflow(o_res_overflow)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int done_pct = 0;

    // Reference model: queues of what each FIFO holds, plus the character on the line
    logic [7:0] eq[$];
    logic [8:0] rq[$];
    logic [7:0] sq[$];
    logic       m_v = 1'b0;
    int         m_src = 0;
    bit         m_in_line = 1'b0;
    logic       m_eovf = 1'b0;
    logic       m_rovf = 1'b0;
    int         edge_n = 0;
    logic [7:0] exp_d[$];
    int         exp_c[$];

    bit         e_acc, r_acc, r_full, elig;
    logic [8:0] tmp9;
    logic       prev_v = 1'b0;
    logic [7:0] held = '0;
    logic [7:0] pop_d;
    int         pop_c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int model_lines();
        int n = 0;
        foreach (rq[i]) if (rq[i][8]) n++;
        return n;
    endfunction

    task automatic present(input logic [7:0] d, input int s);
        m_v   = 1'b1;
        m_src = s;
        exp_d.push_back(d);
        exp_c.push_back(edge_n);
    endtask

    // Model update at every rising edge using the inputs that the DUT samples there
    always @(posedge i_clk) begin
        edge_n++;
        if (i_rst) begin
            eq.delete(); rq.delete(); sq.delete();
            m_v = 1'b0; m_in_line = 1'b0; m_eovf = 1'b0; m_rovf = 1'b0;
        end else begin
            e_acc  = EEN && i_echo_valid && (eq.size() < ED);
            r_full = (rq.size() == RD);
            r_acc  = i_res_valid && !r_full;
            elig   = (model_lines() > 0) || r_full;
            if (m_v) begin
                if (i_tx_done) begin
                    m_v = 1'b0;
                    if (m_src == 0) void'(eq.pop_front());
                    else if (m_src == 1) begin
                        tmp9 = rq.pop_front();
                        if (tmp9[8]) begin
                            m_in_line = 1'b0;
                            if (CEN) begin sq.push_back(CR); sq.push_back(LF); end
                        end
                    end else void'(sq.pop_front());
                end
            end else if (sq.size() > 0) begin
                present(sq[0], 2);
            end else if (m_in_line) begin
                if (rq.size() > 0) begin tmp9 = rq[0]; present(tmp9[7:0], 1); end
            end else if (elig && (eq.size() == 0 || r_full)) begin
                m_in_line = 1'b1;
                tmp9 = rq[0];
                present(tmp9[7:0], 1);
            end else if (eq.size() > 0) begin
                present(eq[0], 0);
            end
            if (e_acc) eq.push_back(i_echo_data);
            else if (EEN && i_echo_valid) m_eovf = 1'b1;
            if (r_acc) rq.push_back({i_res_last, i_res_data});
            else if (i_res_valid) m_rovf = 1'b1;
        end
    end

    // UART stand-in: random done pulses, applied after the main process updates done_pct
    always @(posedge i_clk) begin
        #2;
        i_tx_done = ($urandom_range(0, 99) < done_pct);
    end

    // Monitor: per-cycle status checks and scoreboard pop on every new character
    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("tx_valid", {31'd0, o_tx_valid}, {31'd0, m_v});
            chk("res_ready", {31'd0, o_res_ready}, {31'd0, rq.size() < RD});
            chk("echo_overflow", {31'd0, o_echo_overflow}, {31'd0, m_eovf});
            chk("res_overflow", {31'd0, o_res_overflow}, {31'd0, m_rovf});
            if (o_tx_valid === 1'b1 && !prev_v) begin
                if (exp_d.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_tx: got %0h expected none", o_tx_data);
                end else begin
                    pop_d = exp_d.pop_front();
                    pop_c = exp_c.pop_front();
                    chk("tx_data", {24'd0, o_tx_data}, {24'd0, pop_d});
                    chk("tx_cycle", edge_n, pop_c);
                end
                held = o_tx_data;
            end else if (o_tx_valid === 1'b1) begin
                chk("tx_stable", {24'd0, o_tx_data}, {24'd0, held});
            end
            prev_v = (o_tx_valid === 1'b1);
        end
    end

    task automatic tick(input logic ev, input logic [7:0] ed, input logic rv,
                        input logic [7:0] rdat, input logic rl);
        i_echo_valid = ev; i_echo_data = ed;
        i_res_valid = rv; i_res_data = rdat; i_res_last = rl;
        @(posedge i_clk); #1;
        i_echo_valid = 1'b0; i_res_valid = 1'b0; i_res_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        done_pct = 60;
        for (int k = 0; k < 3000; k++) begin
            if (!m_v && eq.size() == 0 && rq.size() == 0 && sq.size() == 0) begin
                ok = 1'b1;
                break;
            end
            if (model_lines() == 0 && (m_in_line || rq.size() > 0) && rq.size() < RD)
                tick(1'b0, 8'h00, 1'b1, 8'h2E, 1'b1);
            else
                idle(1);
        end
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL drain_timeout: got busy expected idle within 3000 cycles");
        end
        done_pct = 0;
        idle(2);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_tx_valid"}, {31'd0, o_tx_valid}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, o_tx_data}, 32'd0);
        chk({tag, "_echo_ovf"}, {31'd0, o_echo_overflow}, 32'd0);
        chk({tag, "_res_ovf"}, {31'd0, o_res_overflow}, 32'd0);
        chk({tag, "_res_ready"}, {31'd0, o_res_ready}, 32'd1);
    endtask

    initial begin
        bit got_lf;
        repeat (3) @(posedge i_clk);
        #1;
        reset_checks("reset");
        i_rst = 1'b0;
        chk_en = 1'b1;

        // Echo only, held for 50 cycles, then a single done pulse
        tick(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
        idle(50);
        done_pct = 100; idle(1); done_pct = 0;
        idle(4);

        // Result line "12" with CR/LF framing
        tick(1'b0, 8'h00, 1'b1, 8'h31, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 8'h32, 1'b1);
        drain();

        // Echo arrives while a result line is on the wire
        tick(1'b0, 8'h00, 1'b1, 8'h37, 1'b1);
        idle(3);
        tick(1'b1, 8'h78, 1'b0, 8'h00, 1'b0);
        drain();

        // Fill result FIFO without last: forced flush, 13th write dropped
        for (int i = 0; i < RD; i++) tick(1'b0, 8'h00, 1'b1, 8'(8'h61 + i), 1'b0);
        tick(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
        idle(3);
        chk("full_res_ready", {31'd0, o_res_ready}, 32'd0);
        chk("full_res_ovf", {31'd0, o_res_overflow}, 32'd1);
        drain();

        // Echo overflow, drain, then wrap the pointers
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h70 + i), 1'b0, 8'h00, 1'b0);
        idle(2);
        chk("echo_ovf_set", {31'd0, o_echo_overflow}, 32'd1);
        drain();
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h50 + i), 1'b0, 8'h00, 1'b0);
        drain();

        // Reset while LF is pending on the line
        tick(1'b0, 8'h00, 1'b1, 8'h72, 1'b1);
        got_lf = 1'b0;
        done_pct = 100;
        for (int k = 0; k < 200; k++) begin
            idle(1);
            if (o_tx_valid === 1'b1 && o_tx_data === LF) begin
                done_pct = 0;
                got_lf = 1'b1;
                break;
            end
        end
        done_pct = 0;
        n_vec++;
        if (!got_lf) begin
            n_bad++;
            $display("FAIL lf_pending: got no LF expected LF within 200 cycles");
        end
        idle(1);
        i_rst = 1'b1;
        idle(1);
        i_rst = 1'b0;
        reset_checks("midreset");
        tick(1'b1, 8'h6E, 1'b0, 8'h00, 1'b0);
        drain();

        // Randomised traffic on both streams
        done_pct = 40;
        repeat (3000) begin
            tick($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 2) == 0,
                 8'($urandom), $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 199) == 0) done_pct = $urandom_range(0, 100);
        end
        drain();

        chk("scoreboard_empty", exp_d.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
